// File: rtl/rear_light_scheduler.sv
// rear_light_scheduler: produces registered 10-bit duty commands for the left and
// right rear-lamp PWM generators from brake, headlight, turn and hazard requests.
// Adds a hard-brake stop-flash pattern and a turn/hazard blinker.
//
// Ports:
//   c50M            system clock (50 MHz)
//   reset           synchronous, active-high reset
//   brakeActive     brake pedal pressed
//   hardBrake       emergency deceleration, sampled on the brake rising edge
//   headLightActive headlight on (dim tail light when brake idle)
//   turnLeft/Right  turn requests (both together behave as hazard)
//   hazard          hazard switch
//   leftDuty        left lamp duty command
//   rightDuty       right lamp duty command
//   blinkPhase      current blink phase (1 = on), dash indicator
//   flashBusy       stop-flash sequence in progress
//
// Optional feature: define LIGHT_FADE_EN to slew the duty outputs toward their
// target by FADE_STEP per tick (brake-caused full-on still jumps immediately).
module rear_light_scheduler #(
  parameter int unsigned TICK_DIV    = 50000,
  parameter int unsigned BLINK_HALF  = 333,
  parameter int unsigned FLASH_HALF  = 62,
  parameter int unsigned FLASH_COUNT = 4,
  parameter logic [9:0]  DIM_DUTY    = 10'd31,
  parameter logic [9:0]  FULL_DUTY   = 10'd1023
) (
  input  logic       c50M,
  input  logic       reset,
  input  logic       brakeActive,
  input  logic       hardBrake,
  input  logic       headLightActive,
  input  logic       turnLeft,
  input  logic       turnRight,
  input  logic       hazard,
  output logic [9:0] leftDuty,
  output logic [9:0] rightDuty,
  output logic       blinkPhase,
  output logic       flashBusy
);

  localparam int unsigned TW = (TICK_DIV > 2)   ? $clog2(TICK_DIV)   : 1;
  localparam int unsigned BW = (BLINK_HALF > 2) ? $clog2(BLINK_HALF) : 1;
  localparam int unsigned HW = (FLASH_HALF > 2) ? $clog2(FLASH_HALF) : 1;
  localparam int unsigned CW = $clog2(FLASH_COUNT + 1);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_FLASH_ON  = 2'd1,
    ST_FLASH_OFF = 2'd2,
    ST_STEADY    = 2'd3
  } state_e;

  logic [TW-1:0] presc_q, presc_d;
  logic          tick_c;
  logic          blink_en_c, blink_en_q, blink_en_d;
  logic          blink_phase_q, blink_phase_d, phase_eff_c;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          brake_q, brake_d;
  state_e        state_q, state_d;
  logic [HW-1:0] half_cnt_q, half_cnt_d;
  logic [CW-1:0] flash_cnt_q, flash_cnt_d;
  logic          flash_busy_q, flash_busy_d;
  logic [9:0]    left_duty_q, left_duty_d, right_duty_q, right_duty_d;
  logic [9:0]    left_tgt_c, right_tgt_c;
  logic          left_blink_c, right_blink_c, brake_full_c;

  // Target duty for one side in priority order: blink, brake, dim tail light.
  function automatic logic [9:0] side_target(input logic blink, input logic phase,
                                             input state_e st, input logic head);
    logic [9:0] t;
    t = '0;
    if (blink)                                     t = phase ? FULL_DUTY : 10'd0;
    else if (st == ST_STEADY || st == ST_FLASH_ON) t = FULL_DUTY;
    else if (st == ST_FLASH_OFF)                   t = 10'd0;
    else if (head)                                 t = DIM_DUTY;
    return t;
  endfunction

  // Free-running tick prescaler.
  always_comb begin
    tick_c  = (presc_q == TW'(TICK_DIV - 1));
    presc_d = tick_c ? '0 : presc_q + TW'(1);
  end

  // Blink timer: phase forced on at enable rise, forced off while disabled.
  always_comb begin
    blink_en_c    = hazard | turnLeft | turnRight;
    blink_en_d    = blink_en_c;
    blink_phase_d = blink_phase_q;
    blink_cnt_d   = blink_cnt_q;
    if (blink_en_c && !blink_en_q) begin
      blink_phase_d = 1'b1;
      blink_cnt_d   = '0;
    end else if (!blink_en_c) begin
      blink_phase_d = 1'b0;
      blink_cnt_d   = '0;
    end else if (tick_c) begin
      if (blink_cnt_q == BW'(BLINK_HALF - 1)) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BW'(1);
      end
    end
  end

  // Brake FSM next-state; releasing the pedal always returns to IDLE.
  always_comb begin
    state_d     = state_q;
    half_cnt_d  = half_cnt_q;
    flash_cnt_d = flash_cnt_q;
    brake_d     = brakeActive;
    if (!brakeActive) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (!brake_q) begin
            state_d     = hardBrake ? ST_FLASH_ON : ST_STEADY;
            half_cnt_d  = '0;
            flash_cnt_d = '0;
          end
        end
        ST_FLASH_ON: begin
          if (tick_c) begin
            if (half_cnt_q == HW'(FLASH_HALF - 1)) begin
              half_cnt_d = '0;
              state_d    = ST_FLASH_OFF;
            end else begin
              half_cnt_d = half_cnt_q + HW'(1);
            end
          end
        end
        ST_FLASH_OFF: begin
          if (tick_c) begin
            if (half_cnt_q == HW'(FLASH_HALF - 1)) begin
              half_cnt_d  = '0;
              flash_cnt_d = flash_cnt_q + CW'(1);
              state_d     = (flash_cnt_q + CW'(1) == CW'(FLASH_COUNT)) ? ST_STEADY : ST_FLASH_ON;
            end else begin
              half_cnt_d = half_cnt_q + HW'(1);
            end
          end
        end
        ST_STEADY: state_d = ST_STEADY;
        default:   state_d = ST_IDLE;
      endcase
    end
    flash_busy_d = (state_d == ST_FLASH_ON) || (state_d == ST_FLASH_OFF);
  end

  // Per-side targets; a freshly enabled blinker starts in the on phase.
  always_comb begin
    phase_eff_c   = blink_phase_q | (blink_en_c & ~blink_en_q);
    left_blink_c  = hazard | turnLeft;
    right_blink_c = hazard | turnRight;
    brake_full_c  = (state_q == ST_STEADY) || (state_q == ST_FLASH_ON);
    left_tgt_c    = side_target(left_blink_c,  phase_eff_c, state_q, headLightActive);
    right_tgt_c   = side_target(right_blink_c, phase_eff_c, state_q, headLightActive);
  end

`ifdef LIGHT_FADE_EN
  localparam logic [9:0] FADE_STEP = 10'd64;

  // One slew step toward the target, clamped so it never overshoots.
  function automatic logic [9:0] slew(input logic [9:0] cur, input logic [9:0] tgt);
    logic [9:0] r;
    r = cur;
    if (tgt > cur)      r = ((tgt - cur) > FADE_STEP) ? cur + FADE_STEP : tgt;
    else if (tgt < cur) r = ((cur - tgt) > FADE_STEP) ? cur - FADE_STEP : tgt;
    return r;
  endfunction

  // Brake-driven full-on bypasses the slew so the safety path is never delayed.
  always_comb begin
    left_duty_d  = left_duty_q;
    right_duty_d = right_duty_q;
    if (!left_blink_c && brake_full_c) left_duty_d = FULL_DUTY;
    else if (tick_c)                   left_duty_d = slew(left_duty_q, left_tgt_c);
    if (!right_blink_c && brake_full_c) right_duty_d = FULL_DUTY;
    else if (tick_c)                    right_duty_d = slew(right_duty_q, right_tgt_c);
  end
`else
  always_comb begin
    left_duty_d  = left_tgt_c;
    right_duty_d = right_tgt_c;
  end
`endif

  // State and output registers.
  always_ff @(posedge c50M) begin
    if (reset) begin
      presc_q       <= '0;
      blink_en_q    <= 1'b0;
      blink_phase_q <= 1'b0;
      blink_cnt_q   <= '0;
      brake_q       <= 1'b0;
      state_q       <= ST_IDLE;
      half_cnt_q    <= '0;
      flash_cnt_q   <= '0;
      flash_busy_q  <= 1'b0;
      left_duty_q   <= '0;
      right_duty_q  <= '0;
    end else begin
      presc_q       <= presc_d;
      blink_en_q    <= blink_en_d;
      blink_phase_q <= blink_phase_d;
      blink_cnt_q   <= blink_cnt_d;
      brake_q       <= brake_d;
      state_q       <= state_d;
      half_cnt_q    <= half_cnt_d;
      flash_cnt_q   <= flash_cnt_d;
      flash_busy_q  <= flash_busy_d;
      left_duty_q   <= left_duty_d;
      right_duty_q  <= right_duty_d;
    end
  end

  assign leftDuty   = left_duty_q;
  assign rightDuty  = right_duty_q;
  assign blinkPhase = blink_phase_q;
  assign flashBusy  = flash_busy_q;

endmodule

// File: tb/tb_rear_light_scheduler.sv
// Self-checking bench for rear_light_scheduler with small timing parameters.
module tb_rear_light_scheduler;

  localparam int TICK_DIV = 4;
  localparam int BH       = 3;
  localparam int FH       = 2;
  localparam int FC       = 2;
  localparam int FULL     = 1023;
  localparam int DIM      = 31;

  logic       c50M = 1'b0;
  logic       reset, brakeActive, hardBrake, headLightActive;
  logic       turnLeft, turnRight, hazard;
  logic [9:0] leftDuty, rightDuty;
  logic       blinkPhase, flashBusy;

  int checks = 0;
  int errors = 0;

  always #5 c50M = ~c50M;

  rear_light_scheduler #(
    .TICK_DIV(TICK_DIV), .BLINK_HALF(BH), .FLASH_HALF(FH), .FLASH_COUNT(FC),
    .DIM_DUTY(10'd31), .FULL_DUTY(10'd1023)
  ) dut (
    .c50M(c50M), .reset(reset), .brakeActive(brakeActive), .hardBrake(hardBrake),
    .headLightActive(headLightActive), .turnLeft(turnLeft), .turnRight(turnRight),
    .hazard(hazard), .leftDuty(leftDuty), .rightDuty(rightDuty),
    .blinkPhase(blinkPhase), .flashBusy(flashBusy)
  );

  // Reference model: time is measured in ticks elapsed since the brake press
  // and since the blinker was switched on.
  int m_edges, m_brake_prev, m_active, m_hard, m_bk;
  int m_blink_prev, m_blink_on, m_blk;
  int exp_left, exp_right, exp_phase, exp_busy;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  // 0 idle, 1 flash on, 2 flash off, 3 steady
  function automatic int brake_mode();
    int p;
    if (m_active == 0) return 0;
    if (m_hard == 0) return 3;
    p = m_bk / FH;
    if (p >= 2 * FC) return 3;
    return (p % 2 == 0) ? 1 : 2;
  endfunction

  function automatic int blink_ph();
    return (m_blink_on != 0 && ((m_blk / BH) % 2 == 0)) ? 1 : 0;
  endfunction

  function automatic int side(input int blinking, input int ph, input int bm, input int head);
    if (blinking != 0) return (ph != 0) ? FULL : 0;
    if (bm == 1 || bm == 3) return FULL;
    if (bm == 2) return 0;
    return (head != 0) ? DIM : 0;
  endfunction

  task automatic model_step();
    int bm, ph, en, tk;
    if (reset) begin
      m_edges = 0; m_brake_prev = 0; m_active = 0; m_hard = 0; m_bk = 0;
      m_blink_prev = 0; m_blink_on = 0; m_blk = 0;
      exp_left = 0; exp_right = 0; exp_phase = 0; exp_busy = 0;
      return;
    end
    en = (hazard | turnLeft | turnRight) ? 1 : 0;
    bm = brake_mode();
    ph = (en != 0 && m_blink_prev == 0) ? 1 : blink_ph();
    exp_left  = side(int'(hazard | turnLeft),  ph, bm, int'(headLightActive));
    exp_right = side(int'(hazard | turnRight), ph, bm, int'(headLightActive));
    m_edges++;
    tk = (m_edges % TICK_DIV == 0) ? 1 : 0;
    if (!brakeActive) m_active = 0;
    else if (m_brake_prev == 0) begin
      m_active = 1; m_hard = int'(hardBrake); m_bk = 0;
    end else if (m_active != 0 && tk != 0 && m_bk < 100000) m_bk++;
    m_brake_prev = int'(brakeActive);
    if (en != 0 && m_blink_prev == 0) begin
      m_blink_on = 1; m_blk = 0;
    end else if (en == 0) m_blink_on = 0;
    else if (tk != 0) m_blk++;
    m_blink_prev = en;
    exp_phase = blink_ph();
    bm = brake_mode();
    exp_busy = (bm == 1 || bm == 2) ? 1 : 0;
  endtask

  // One clock: model follows the edge, outputs are sampled 1 time unit later.
  task automatic cycle();
    @(posedge c50M);
    model_step();
    #1;
    check("model_left",  int'(leftDuty),   exp_left);
    check("model_right", int'(rightDuty),  exp_right);
    check("model_phase", int'(blinkPhase), exp_phase);
    check("model_busy",  int'(flashBusy),  exp_busy);
  endtask

  task automatic set_in(input logic rst, input logic brk, input logic hb, input logic hd,
                        input logic tl, input logic tr, input logic hz);
    reset = rst; brakeActive = brk; hardBrake = hb; headLightActive = hd;
    turnLeft = tl; turnRight = tr; hazard = hz;
  endtask

  task automatic runs_of(input int d[$], output int lens[$], output int vals[$]);
    lens = {}; vals = {};
    foreach (d[i]) begin
      if (i == 0 || d[i] != d[i-1]) begin
        lens.push_back(1); vals.push_back(d[i]);
      end else lens[lens.size()-1]++;
    end
  endtask

  typedef struct {
    logic rst, brk, hb, hd, tl, tr, hz;
    int   n;
    int   l, r, ph, busy;
  } vec_t;

  vec_t vt[14];
  int   dq[$], rl[$], rv[$], rq[$];
  int   found, bad;

  initial begin
    vt[0]  = '{1,1,1,1,1,1,1, 3,    0,    0, 0, 0};
    vt[1]  = '{0,0,0,0,0,0,0, 1,    0,    0, 0, 0};
    vt[2]  = '{0,0,0,1,0,0,0, 2,  DIM,  DIM, 0, 0};
    vt[3]  = '{0,1,0,1,0,0,0, 1,  DIM,  DIM, 0, 0};
    vt[4]  = '{0,1,0,1,0,0,0, 1, FULL, FULL, 0, 0};
    vt[5]  = '{0,0,0,1,0,0,0, 2,  DIM,  DIM, 0, 0};
    vt[6]  = '{0,0,0,1,1,1,0, 1, FULL, FULL, 1, 0};
    vt[7]  = '{0,0,0,1,1,1,0, 1, FULL, FULL, 1, 0};
    vt[8]  = '{0,0,0,1,0,0,0, 1,  DIM,  DIM, 0, 0};
    vt[9]  = '{1,0,0,0,0,0,0, 1,    0,    0, 0, 0};
    vt[10] = '{0,1,1,0,0,0,0, 1,    0,    0, 0, 1};
    vt[11] = '{0,1,1,0,0,0,0, 1, FULL, FULL, 0, 1};
    vt[12] = '{0,0,1,0,0,0,0, 1, FULL, FULL, 0, 0};
    vt[13] = '{0,0,0,0,0,0,0, 1,    0,    0, 0, 0};

    set_in(1,1,1,1,1,1,1);
    for (int i = 0; i < 14; i++) begin
      set_in(vt[i].rst, vt[i].brk, vt[i].hb, vt[i].hd, vt[i].tl, vt[i].tr, vt[i].hz);
      repeat (vt[i].n) cycle();
      check($sformatf("vec%0d_left", i),  int'(leftDuty),   vt[i].l);
      check($sformatf("vec%0d_right", i), int'(rightDuty),  vt[i].r);
      check($sformatf("vec%0d_phase", i), int'(blinkPhase), vt[i].ph);
      check($sformatf("vec%0d_busy", i),  int'(flashBusy),  vt[i].busy);
    end

    // Hard-brake flash pattern: middle levels last exactly FH ticks each.
    set_in(1,0,0,0,0,0,0); cycle();
    set_in(0,1,1,0,0,0,0);
    dq = {};
    for (int i = 0; i < 50; i++) begin cycle(); dq.push_back(int'(leftDuty)); end
    runs_of(dq, rl, rv);
    check("flash_levels", rl.size(), 6);
    if (rl.size() == 6) begin
      check("flash_first_on", rv[1], FULL);
      for (int i = 2; i < 5; i++) check($sformatf("flash_run%0d", i), rl[i], FH * TICK_DIV);
      check("flash_final", rv[5], FULL);
    end
    check("flash_done_busy", int'(flashBusy), 0);

    // Release in the middle of FLASH_OFF.
    set_in(1,0,0,0,0,0,0); cycle();
    set_in(0,1,1,0,0,0,0);
    found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      cycle();
      if (leftDuty == 10'd0 && flashBusy && i > 1) found = 1;
    end
    check("flash_off_reached", found, 1);
    cycle(); cycle();
    set_in(0,0,0,0,0,0,0);
    cycle();
    check("abort_busy", int'(flashBusy), 0);
    cycle();
    check("abort_left", int'(leftDuty), 0);
    check("abort_right", int'(rightDuty), 0);

    // Left turn during steady brake.
    set_in(1,0,0,0,0,0,0); cycle();
    set_in(0,1,0,0,0,0,0); repeat (3) cycle();
    set_in(0,1,0,0,1,0,0);
    dq = {}; bad = 0;
    for (int i = 0; i < 60; i++) begin
      cycle();
      dq.push_back(int'(leftDuty));
      if (rightDuty != 10'd1023) bad++;
    end
    check("turn_right_steady", bad, 0);
    runs_of(dq, rl, rq);
    check("turn_first_level", rq[0], FULL);
    check("turn_enough_runs", int'(rl.size() >= 5), 1);
    if (rl.size() >= 5)
      for (int i = 1; i < 4; i++) check($sformatf("turn_run%0d", i), rl[i], BH * TICK_DIV);
    set_in(0,1,0,0,0,0,0);
    cycle();
    check("turn_off_left", int'(leftDuty), FULL);
    check("turn_off_phase", int'(blinkPhase), 0);

    // Randomized stimulus against the model.
    set_in(1,0,0,0,0,0,0); cycle();
    set_in(0,0,0,0,0,0,0);
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(29, 0) == 0)  brakeActive     = ~brakeActive;
      if ($urandom_range(59, 0) == 0)  turnLeft        = ~turnLeft;
      if ($urandom_range(59, 0) == 0)  turnRight       = ~turnRight;
      if ($urandom_range(119, 0) == 0) hazard          = ~hazard;
      if ($urandom_range(79, 0) == 0)  headLightActive = ~headLightActive;
      hardBrake = ($urandom_range(2, 0) != 0);
      reset     = ($urandom_range(699, 0) == 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
